// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_conditioner_pkg
// Shared types and helpers for the push-button conditioning front end.
//   key_state_t : per-channel debounce FSM state encoding
//   cnt_width() : width of a counter able to reach the largest of three
//                 cycle counts without wrapping
// Optional feature macro used by this slice: KEY_REPEAT_EN
// -----------------------------------------------------------------------------
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_W = 2'd1,
        PRESSED = 2'd2,
        REL_W   = 2'd3
    } key_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
// Bundle of the key signals between the board pins and the consumers.
//   key_raw_n   : raw active-low buttons (driven by master)
//   key_level   : debounced level, 1 = pressed
//   key_press   : one-cycle strobe on accepted press
//   key_release : one-cycle strobe on accepted release
//   key_repeat  : one-cycle auto-repeat strobe (0 unless KEY_REPEAT_EN)
// modport master : board/stimulus side; modport slave : the conditioner
// -----------------------------------------------------------------------------
interface key_conditioner_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] key_raw_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_raw_n,
        input  key_level, key_press, key_release, key_repeat
    );

    modport slave (
        input  key_raw_n,
        output key_level, key_press, key_release, key_repeat
    );
endinterface

// File: rtl/key_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-FF synchroniser, debounce FSM with stability counter,
// debounced level and registered press/release strobes. With KEY_REPEAT_EN
// defined, a repeat counter emits key_repeat while the key stays pressed.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_raw_n    : raw active-low button (asynchronous)
//   key_level    : debounced level (1 = pressed)
//   key_press    : one-cycle strobe on accepted press
//   key_release  : one-cycle strobe on accepted release
//   key_repeat   : one-cycle auto-repeat strobe (tied 0 without KEY_REPEAT_EN)
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Synchroniser holds raw polarity so reset value 1 means "released".
    logic sync_p0, sync_p1;
    logic s;

    key_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          press_nxt, release_nxt;

    // ---- stage p0/p1: metastability chain ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_raw_n;
            sync_p1 <= sync_p0;
        end
    end

    assign s       = ~sync_p1;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // ---- debounce FSM ----
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        state_nxt = PRESS_W;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            PRESS_W: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        state_nxt = REL_W;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            REL_W: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Level follows the registered state, so it flips with the strobe.
    assign key_level = (state == PRESSED) || (state == REL_W);

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rpt_cnt, rpt_cnt_nxt;
    logic          rpt_periodic, rpt_periodic_nxt;
    logic          repeat_nxt;

    // ---- auto-repeat: first interval is the delay, then the period ----
    // Counter is held at 0 outside PRESSED, so every entry restarts the delay.
    always_comb begin
        rpt_cnt_nxt      = '0;
        rpt_periodic_nxt = 1'b0;
        repeat_nxt       = 1'b0;
        if (state == PRESSED && state_nxt == PRESSED) begin
            rpt_periodic_nxt = rpt_periodic;
            if (rpt_cnt == (rpt_periodic ? PER_LAST : DLY_LAST)) begin
                repeat_nxt       = 1'b1;
                rpt_cnt_nxt      = '0;
                rpt_periodic_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = (rpt_cnt == CNT_MAX) ? rpt_cnt : rpt_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
            key_repeat   <= 1'b0;
        end else begin
            rpt_cnt      <= rpt_cnt_nxt;
            rpt_periodic <= rpt_periodic_nxt;
            key_repeat   <= repeat_nxt;
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Conditions N_KEYS raw active-low push-buttons into debounced levels and
// one-cycle press/release (and optional repeat) strobes.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   kif    : key_conditioner_if.slave (key_raw_n in; key_level, key_press,
//            key_release, key_repeat out)
// Optional feature macro: KEY_REPEAT_EN (enables auto-repeat strobes)
// -----------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    key_conditioner_if.slave    kif
);
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw_n   (kif.key_raw_n[i]),
            .key_level   (kif.key_level[i]),
            .key_press   (kif.key_press[i]),
            .key_release (kif.key_release[i]),
            .key_repeat  (kif.key_repeat[i])
        );
    end
endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5, N_KEYS=3. Repeat expectations follow KEY_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_key_conditioner;
    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    key_conditioner_if #(.N_KEYS(N)) kif ();

    key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_idle();
        kif.key_raw_n = '1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [N-1:0] pat;
        logic [4*N-1:0] outs;
        rst_n = 1'b0;
        kif.key_raw_n = '1;
        #3;
        for (int k = 0; k < 8; k++) begin
            pat = N'(k);
            kif.key_raw_n = pat;
            tick();
            outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b exp=0", k, outs);
            end
        end
        kif.key_raw_n = '1;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b exp=0", k, outs);
            end
        end
    endtask

    task automatic test_press();
        logic [N-1:0] ep, el;
        kif.key_raw_n = 3'b110;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ep = (k == 6) ? 3'b001 : 3'b000;
            el = (k >= 6) ? 3'b001 : 3'b000;
            checks++;
            if (kif.key_press !== ep) begin
                errors++;
                $display("FAIL press k=%0d got=%b exp=%b", k, kif.key_press, ep);
            end
            checks++;
            if (kif.key_level !== el) begin
                errors++;
                $display("FAIL press_level k=%0d got=%b exp=%b", k, kif.key_level, el);
            end
        end
    endtask

    task automatic test_release();
        logic [N-1:0] er, el;
        kif.key_raw_n = 3'b111;
        for (int k = 1; k <= 10; k++) begin
            tick();
            er = (k == 6) ? 3'b001 : 3'b000;
            el = (k >= 6) ? 3'b000 : 3'b001;
            checks++;
            if (kif.key_release !== er) begin
                errors++;
                $display("FAIL release k=%0d got=%b exp=%b", k, kif.key_release, er);
            end
            checks++;
            if (kif.key_level !== el) begin
                errors++;
                $display("FAIL release_level k=%0d got=%b exp=%b", k, kif.key_level, el);
            end
            checks++;
            if (kif.key_press !== 3'b000) begin
                errors++;
                $display("FAIL release_nopress k=%0d got=%b exp=000", k, kif.key_press);
            end
        end
    endtask

    task automatic test_glitch();
        kif.key_raw_n = 3'b110;
        repeat (10) tick();
        kif.key_raw_n = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) kif.key_raw_n = 3'b110;
            checks++;
            if ({kif.key_press, kif.key_release, kif.key_level} !== 9'b000_000_001) begin
                errors++;
                $display("FAIL glitch k=%0d got=%b_%b_%b exp=000_000_001", k,
                         kif.key_press, kif.key_release, kif.key_level);
            end
        end
        settle_idle();
    endtask

    task automatic test_bounce();
        int presses;
        logic [N-1:0] ep;
        presses = 0;
        kif.key_raw_n = 3'b101;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (kif.key_press[1]) presses++;
            if (k == 2) kif.key_raw_n = 3'b111;
            if (k == 3) kif.key_raw_n = 3'b101;
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (kif.key_press[1]) presses++;
            ep = (k == 6) ? 3'b010 : 3'b000;
            checks++;
            if (kif.key_press !== ep) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, kif.key_press, ep);
            end
        end
        checks++;
        if (presses !== 1) begin
            errors++;
            $display("FAIL bounce_count got=%0d exp=1", presses);
        end
        settle_idle();
    endtask

    task automatic test_all_keys();
        logic [N-1:0] ep;
        kif.key_raw_n = 3'b000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ep = (k == 6) ? 3'b111 : 3'b000;
            checks++;
            if (kif.key_press !== ep) begin
                errors++;
                $display("FAIL all_keys k=%0d got=%b exp=%b", k, kif.key_press, ep);
            end
        end
        settle_idle();
    endtask

    task automatic test_repeat_and_reset();
        logic [N-1:0] ep, erp, el;
        logic [4*N-1:0] outs;
        kif.key_raw_n = 3'b110;
        for (int k = 1; k <= 35; k++) begin
            tick();
            ep = (k == 6) ? 3'b001 : 3'b000;
`ifdef KEY_REPEAT_EN
            erp = (k == 16 || k == 21 || k == 26 || k == 31) ? 3'b001 : 3'b000;
`else
            erp = 3'b000;
`endif
            checks++;
            if (kif.key_press !== ep) begin
                errors++;
                $display("FAIL hold_press k=%0d got=%b exp=%b", k, kif.key_press, ep);
            end
            checks++;
            if (kif.key_repeat !== erp) begin
                errors++;
                $display("FAIL repeat k=%0d got=%b exp=%b", k, kif.key_repeat, erp);
            end
        end
        rst_n = 1'b0;
        #2;
        outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_repeat};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0", outs);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            ep = (k == 6) ? 3'b001 : 3'b000;
            el = (k >= 6) ? 3'b001 : 3'b000;
            checks++;
            if (kif.key_press !== ep || kif.key_release !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_press k=%0d got=%b/%b exp=%b/000", k,
                         kif.key_press, kif.key_release, ep);
            end
            checks++;
            if (kif.key_level !== el) begin
                errors++;
                $display("FAIL post_reset_level k=%0d got=%b exp=%b", k, kif.key_level, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_bounce();
        test_all_keys();
        test_repeat_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
